pipe_pass_detect: RTL and testbench



---
 rtl/pipe_pass_detect.sv | 124 ++++++++++++
 tb/tb_pipe_pass_detect.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_pass_detect.sv
// Scoring/collision stage: samples pipe occupancy at the bird column on each step, pulses incr per pipe cleared, sticky lose on collision.
// Latency: step edge -> incr/lose/playing/pass_count visible one clk later; no other pipelining.
// Backpressure: none; evaluation happens only on step strobes, which arrive at least 4 clks apart.
module pipe_pass_detect #(
    parameter int ROWS       = 16,
    parameter int FLOOR_KILL = 1,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     step,
    input  logic [$clog2(ROWS)-1:0]  bird_row,
    input  logic [ROWS-1:0]          pipe_col,
    output logic                     incr,
    output logic                     lose,
    output logic                     playing,
    output logic [CNT_W-1:0]         pass_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        IDLE       = 2'd1,
        IN_PIPE    = 2'd2,
        DEAD       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             incr_q, incr_d;
    logic             lose_q, lose_d;
    logic             playing_q, playing_d;
    logic [CNT_W-1:0] pass_count_q, pass_count_d;

    logic present;
    logic row_oob;
    logic wall_hit;
    logic floor_hit;
    logic hit;

    // Collision and pipe-presence terms from the current column; an
    // out-of-range row is treated as fatal and never indexes the column.
    always_comb begin
        present   = |pipe_col;
        row_oob   = (int'(bird_row) >= ROWS);
        wall_hit  = 1'b0;
        if (!row_oob) begin
            wall_hit = pipe_col[bird_row];
        end
        floor_hit = (FLOOR_KILL != 0) && (int'(bird_row) == ROWS - 1);
        hit       = wall_hit | floor_hit | row_oob;
    end

    // Next state and registered-output values; hit outranks a pipe exit.
    always_comb begin
        state_d = state_q;
        incr_d  = 1'b0;
        unique case (state_q)
            WAIT_START: begin
                if (start) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (step) begin
                    if (hit) begin
                        state_d = DEAD;
                    end else if (present) begin
                        state_d = IN_PIPE;
                    end
                end
            end
            IN_PIPE: begin
                if (step) begin
                    if (hit) begin
                        state_d = DEAD;
                    end else if (!present) begin
                        state_d = IDLE;
                        incr_d  = 1'b1;
                    end
                end
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = WAIT_START;
            end
        endcase

        lose_d    = lose_q | (state_d == DEAD);
        playing_d = (state_d == IDLE) | (state_d == IN_PIPE);

        pass_count_d = pass_count_q;
        if (incr_d && (pass_count_q != CNT_MAX)) begin
            pass_count_d = pass_count_q + CNT_ONE;
        end
    end

    // State and output registers; synchronous reset wins over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_START;
            incr_q       <= 1'b0;
            lose_q       <= 1'b0;
            playing_q    <= 1'b0;
            pass_count_q <= '0;
        end else begin
            state_q      <= state_d;
            incr_q       <= incr_d;
            lose_q       <= lose_d;
            playing_q    <= playing_d;
            pass_count_q <= pass_count_d;
        end
    end

    assign incr       = incr_q;
    assign lose       = lose_q;
    assign playing    = playing_q;
    assign pass_count = pass_count_q;

endmodule

// File: tb/tb_pipe_pass_detect.sv
// Bench for pipe_pass_detect: directed scenarios plus randomized games against a game-rule reference model.
// Latency: outputs sampled 1 ns after the edge following each step.
// Backpressure: none; steps are issued 4 clks apart.
module tb_pipe_pass_detect;

    logic        clk;
    logic        reset;
    logic        start;
    logic        step;
    logic [3:0]  bird_row;
    logic [15:0] pipe_col;
    logic        incr;
    logic        lose;
    logic        playing;
    logic [7:0]  pass_count;

    int total;
    int bad;

    // reference model of the game rules
    bit m_started;
    bit m_dead;
    bit m_inside;
    int m_count;

    // values sampled by the drive tasks
    logic       s_incr;
    logic       s_lose;
    logic       s_play;
    logic [7:0] s_cnt;
    int         s_extra;

    pipe_pass_detect #(.ROWS(16), .FLOOR_KILL(1), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .step       (step),
        .bird_row   (bird_row),
        .pipe_col   (pipe_col),
        .incr       (incr),
        .lose       (lose),
        .playing    (playing),
        .pass_count (pass_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_started = 0;
        m_dead    = 0;
        m_inside  = 0;
        m_count   = 0;
    endfunction

    // Returns 1 when this step clears a pipe.
    function automatic bit model_step(input logic [3:0] row, input logic [15:0] col);
        bit h;
        if (!m_started || m_dead) return 0;
        h = col[row] || (row == 4'd15);
        if (h) begin
            m_dead = 1;
            return 0;
        end
        if (col == 16'h0) begin
            if (m_inside) begin
                m_inside = 0;
                if (m_count < 255) m_count++;
                return 1;
            end
            return 0;
        end
        m_inside = 1;
        return 0;
    endfunction

    task automatic sample();
        s_incr = incr;
        s_lose = lose;
        s_play = playing;
        s_cnt  = pass_count;
    endtask

    // One step strobe, then 3 quiet clocks; counts any incr seen in the quiet clocks.
    task automatic do_step(input logic [3:0] row, input logic [15:0] col);
        @(negedge clk);
        bird_row = row;
        pipe_col = col;
        step     = 1'b1;
        @(posedge clk);
        #1;
        sample();
        step    = 1'b0;
        s_extra = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (incr !== 1'b0) s_extra++;
        end
    endtask

    task automatic do_start(input bit with_step, input logic [3:0] row, input logic [15:0] col);
        @(negedge clk);
        bird_row = row;
        pipe_col = col;
        start    = 1'b1;
        step     = with_step;
        @(posedge clk);
        #1;
        sample();
        start = 1'b0;
        step  = 1'b0;
        if (!m_dead) m_started = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sample();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (s_incr !== 1'b0) begin bad++; $display("FAIL reset_incr got=%b exp=0", s_incr); end
        total++; if (s_lose !== 1'b0) begin bad++; $display("FAIL reset_lose got=%b exp=0", s_lose); end
        total++; if (s_play !== 1'b0) begin bad++; $display("FAIL reset_playing got=%b exp=0", s_play); end
        total++; if (s_cnt !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", s_cnt); end
    endtask

    task automatic test_idle_steps();
        bit e;
        do_start(1'b0, 4'd5, 16'h0);
        total++; if (s_play !== 1'b1) begin bad++; $display("FAIL start_playing got=%b exp=1", s_play); end
        for (int i = 0; i < 3; i++) begin
            e = model_step(4'd5, 16'h0);
            do_step(4'd5, 16'h0);
            total++; if (s_incr !== e || s_extra != 0) begin bad++; $display("FAIL idle_incr got=%b extra=%0d exp=%b", s_incr, s_extra, e); end
            total++; if (s_play !== 1'b1 || s_lose !== 1'b0) begin bad++; $display("FAIL idle_flags got play=%b lose=%b exp play=1 lose=0", s_play, s_lose); end
        end
        total++; if (s_cnt !== 8'd0) begin bad++; $display("FAIL idle_count got=%0d exp=0", s_cnt); end
    endtask

    task automatic test_pipe_pass();
        bit e;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            e = model_step(4'd5, 16'hFF0F);
            do_step(4'd5, 16'hFF0F);
            pulses += int'(s_incr) + s_extra;
            total++; if (s_incr !== 1'b0) begin bad++; $display("FAIL inpipe_incr got=%b exp=0", s_incr); end
        end
        e = model_step(4'd5, 16'h0);
        do_step(4'd5, 16'h0);
        total++; if (s_incr !== e) begin bad++; $display("FAIL exit_incr got=%b exp=%b", s_incr, e); end
        pulses += int'(s_incr) + s_extra;
        total++; if (pulses != 1) begin bad++; $display("FAIL exit_pulses got=%0d exp=1", pulses); end
        total++; if (s_cnt !== 8'(m_count)) begin bad++; $display("FAIL exit_count got=%0d exp=%0d", s_cnt, m_count); end
    endtask

    task automatic test_collision();
        bit e;
        e = model_step(4'd2, 16'hFF0F);
        do_step(4'd2, 16'hFF0F);
        total++; if (s_lose !== 1'b1) begin bad++; $display("FAIL hit_lose got=%b exp=1", s_lose); end
        total++; if (s_play !== 1'b0) begin bad++; $display("FAIL hit_playing got=%b exp=0", s_play); end
        for (int i = 0; i < 2; i++) begin
            e = model_step(4'd5, 16'hFF0F);
            do_step(4'd5, 16'hFF0F);
            e = model_step(4'd5, 16'h0);
            do_step(4'd5, 16'h0);
            total++; if (s_incr !== e || s_extra != 0) begin bad++; $display("FAIL dead_incr got=%b extra=%0d exp=%b", s_incr, s_extra, e); end
            total++; if (s_lose !== 1'b1 || s_cnt !== 8'(m_count)) begin bad++; $display("FAIL dead_frozen got lose=%b cnt=%0d exp lose=1 cnt=%0d", s_lose, s_cnt, m_count); end
        end
    endtask

    task automatic test_floor_kill();
        bit e;
        do_reset();
        do_start(1'b0, 4'd5, 16'h0);
        e = model_step(4'd5, 16'hFF0F);
        do_step(4'd5, 16'hFF0F);
        e = model_step(4'd15, 16'h0);
        do_step(4'd15, 16'h0);
        total++; if (s_incr !== 1'b0 || s_extra != 0) begin bad++; $display("FAIL floor_incr got=%b extra=%0d exp=0", s_incr, s_extra); end
        total++; if (s_lose !== 1'b1) begin bad++; $display("FAIL floor_lose got=%b exp=1", s_lose); end
        total++; if (s_cnt !== 8'd0) begin bad++; $display("FAIL floor_count got=%0d exp=0", s_cnt); end
    endtask

    task automatic test_pre_start();
        bit e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            e = model_step(4'd2, 16'hFF0F);
            do_step(4'd2, 16'hFF0F);
            total++; if (s_lose !== 1'b0 || s_play !== 1'b0 || s_incr !== 1'b0) begin bad++; $display("FAIL prestart got lose=%b play=%b incr=%b exp all 0", s_lose, s_play, s_incr); end
        end
        do_start(1'b1, 4'd2, 16'hFF0F);
        total++; if (s_lose !== 1'b0 || s_play !== 1'b1) begin bad++; $display("FAIL start_step got lose=%b play=%b exp lose=0 play=1", s_lose, s_play); end
        e = model_step(4'd5, 16'hFF0F);
        do_step(4'd5, 16'hFF0F);
        do_reset();
        total++; if (s_incr !== 1'b0 || s_lose !== 1'b0 || s_play !== 1'b0 || s_cnt !== 8'd0) begin bad++; $display("FAIL midreset got incr=%b lose=%b play=%b cnt=%0d exp all 0", s_incr, s_lose, s_play, s_cnt); end
        e = model_step(4'd5, 16'h0);
        do_step(4'd5, 16'h0);
        total++; if (s_incr !== e || s_play !== 1'b0) begin bad++; $display("FAIL after_reset got incr=%b play=%b exp incr=%b play=0", s_incr, s_play, e); end
    endtask

    task automatic test_saturation();
        bit e;
        int pulses;
        int exp_pulses;
        int cnt_err;
        do_reset();
        do_start(1'b0, 4'd5, 16'h0);
        pulses = 0;
        exp_pulses = 0;
        cnt_err = 0;
        for (int i = 0; i < 260; i++) begin
            e = model_step(4'd5, 16'hFF0F);
            do_step(4'd5, 16'hFF0F);
            pulses += int'(s_incr) + s_extra;
            e = model_step(4'd5, 16'h0);
            do_step(4'd5, 16'h0);
            pulses += int'(s_incr) + s_extra;
            exp_pulses += int'(e);
            if (s_cnt !== 8'(m_count)) cnt_err++;
        end
        total++; if (pulses != exp_pulses) begin bad++; $display("FAIL sat_pulses got=%0d exp=%0d", pulses, exp_pulses); end
        total++; if (cnt_err != 0) begin bad++; $display("FAIL sat_count_track got=%0d exp=0 mismatching passes", cnt_err); end
        total++; if (s_cnt !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d exp=255", s_cnt); end
    endtask

    task automatic test_random();
        bit e;
        int g;
        bit in_col;
        logic [3:0]  row;
        logic [15:0] col;
        logic [15:0] gap_mask;
        for (int game = 0; game < 25; game++) begin
            do_reset();
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                e = model_step(4'($urandom_range(0, 15)), 16'($urandom));
                do_step(4'd0, 16'h0);
            end
            do_start(1'b0, 4'd5, 16'h0);
            g = 6;
            in_col = 0;
            for (int s = 0; s < 30; s++) begin
                if ($urandom_range(0, 2) == 0) begin
                    col = 16'h0;
                    in_col = 0;
                end else begin
                    if (!in_col) g = int'($urandom_range(0, 11));
                    in_col = 1;
                    gap_mask = 16'hF;
                    col = ~(gap_mask << g);
                end
                if ($urandom_range(0, 9) < 8) row = 4'(g + int'($urandom_range(0, 3)));
                else row = 4'($urandom_range(0, 15));
                e = model_step(row, col);
                do_step(row, col);
                total++;
                if (s_incr !== e || s_extra != 0 || s_lose !== m_dead || s_play !== (m_started && !m_dead) || s_cnt !== 8'(m_count)) begin
                    bad++;
                    $display("FAIL rand_step g%0d s%0d got incr=%b extra=%0d lose=%b play=%b cnt=%0d exp incr=%b lose=%b play=%b cnt=%0d",
                             game, s, s_incr, s_extra, s_lose, s_play, s_cnt, e, m_dead, m_started && !m_dead, m_count);
                end
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        bird_row = 4'd0;
        pipe_col = 16'h0;
        model_reset();
        test_reset();
        test_idle_steps();
        test_pipe_pass();
        test_collision();
        test_floor_kill();
        test_pre_start();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
